// File: rtl/phase_meter_pkg.sv
// Shared types/constants for the zero-cross phase meter and the downstream phase-to-speed averager.
// Build option: define GLITCH_FILTER_EN to enable the rx glitch filter.
package phase_meter_pkg;

    localparam int PHASE_W          = 19;
    localparam int CNT_W_DEFAULT    = 18;
    localparam int GLITCH_K_DEFAULT = 3;

`ifdef GLITCH_FILTER_EN
    localparam bit GLITCH_FILTER_BUILD = 1'b1;
`else
    localparam bit GLITCH_FILTER_BUILD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPT
    } pm_state_e;

    typedef struct packed {
        logic                      endata;
        logic signed [PHASE_W-1:0] phase;
    } pm_sample_t;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser + rising-edge pulse; with FILTER set (and the filter build enabled)
// a new level must persist GLITCH_K synchronised samples before its edge is accepted.
module sync_edge_det
    import phase_meter_pkg::*;
#(
    parameter int GLITCH_K = GLITCH_K_DEFAULT,
    parameter bit FILTER   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    // A window of one sample degenerates into a plain edge detector (lvl == previous sample).
    localparam int WIN = (FILTER && GLITCH_FILTER_BUILD) ? GLITCH_K : 1;

    logic [WIN:0] sh;     // sh[0] metastable stage, sh[WIN:1] synchronised history
    logic         lvl;    // last accepted level
    logic         all_hi;
    logic         all_lo;

    assign all_hi = &sh[WIN:1];
    assign all_lo = ~|sh[WIN:1];
    assign rise   = all_hi & ~lvl;

    always_ff @(posedge clock) begin
        if (reset) begin
            sh  <= '0;
            lvl <= 1'b0;
        end else begin
            sh <= {sh[WIN-1:0], din};
            if (all_hi)      lvl <= 1'b1;
            else if (all_lo) lvl <= 1'b0;
        end
    end

endmodule

// File: rtl/zerocross_phase_meter.sv
// Phase lag of rx vs ref rising edges in clock cycles, one signed sample per ref period.
// Build option: GLITCH_FILTER_EN adds a GLITCH_K-sample glitch filter on rx (delay not compensated).
module zerocross_phase_meter
    import phase_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int GLITCH_K = GLITCH_K_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ref_in,
    input  logic                      rx_in,
    output logic signed [PHASE_W-1:0] phase,
    output logic                      endata,
    output logic                      signal_lost
);

    localparam int               NUM_LANES = 2;   // lane 0 ref, lane 1 rx
    localparam logic [CNT_W-1:0] PER_MAX   = '1;

    logic [NUM_LANES-1:0] lane_in;
    logic [NUM_LANES-1:0] lane_rise;
    logic                 ref_rise;
    logic                 rx_rise;

    assign lane_in  = {rx_in, ref_in};
    assign ref_rise = lane_rise[0];
    assign rx_rise  = lane_rise[1];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sync_edge_det #(
            .GLITCH_K (GLITCH_K),
            .FILTER   (i == 1)
        ) u_det (
            .clock (clock),
            .reset (reset),
            .din   (lane_in[i]),
            .rise  (lane_rise[i])
        );
    end

    pm_state_e          state, state_nx;
    logic [CNT_W-1:0]   per, per_nx;
    logic [CNT_W-1:0]   dly, dly_nx;
    logic               close;
    logic               lost_set;
    logic               wrap;
    logic signed [CNT_W:0] diff;
    pm_sample_t         smp;

    // Delays beyond half a period are reported as a lead of the next ref edge.
    assign wrap = dly > (per >> 1);
    assign diff = wrap ? $signed({1'b0, dly}) - $signed({1'b0, per}) : $signed({1'b0, dly});

    always_comb begin
        state_nx = state;
        per_nx   = per;
        dly_nx   = dly;
        close    = 1'b0;
        lost_set = 1'b0;
        case (state)
            IDLE: begin
                if (ref_rise) begin
                    per_nx   = CNT_W'(1);
                    state_nx = ARMED;
                    if (rx_rise) begin
                        dly_nx   = '0;
                        state_nx = CAPT;
                    end
                end
            end
            ARMED, CAPT: begin
                per_nx = per + 1'b1;
                if (ref_rise) begin
                    // ref closes the period first; a coincident rx belongs to the new one
                    close    = (state == CAPT);
                    per_nx   = CNT_W'(1);
                    state_nx = ARMED;
                    if (rx_rise) begin
                        dly_nx   = '0;
                        state_nx = CAPT;
                    end
                end else if (per == PER_MAX) begin
                    lost_set = 1'b1;
                    state_nx = IDLE;
                end else if (rx_rise && state == ARMED) begin
                    dly_nx   = per;
                    state_nx = CAPT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            per         <= '0;
            dly         <= '0;
            smp         <= '0;
            signal_lost <= 1'b0;
        end else begin
            state      <= state_nx;
            per        <= per_nx;
            dly        <= dly_nx;
            smp.endata <= close;
            if (close)         smp.phase   <= PHASE_W'(diff);
            if (lost_set)      signal_lost <= 1'b1;
            else if (ref_rise) signal_lost <= 1'b0;
        end
    end

    assign phase  = smp.phase;
    assign endata = smp.endata;

endmodule
